// File: rtl/rf_write_buffer.sv
// In-order write buffer in front of the register file write port, drained one entry per cycle.
// Define RF_WBUF_FWD_EN to forward still-pending data to the two read ports.
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wr_stall,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic                       fwd_hit1,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              pop, push;

    // The head only changes on posedge, so it is settled for the register file's negedge capture.
    assign pop        = (count_reg != '0) & ~wr_stall;
    assign in_ready   = (count_reg < CW'(DEPTH)) | pop;
    assign push       = in_valid & in_ready;
    assign wr_en      = pop;
    assign write_addr = addr_mem[rd_ptr_reg];
    assign write_data = data_mem[rd_ptr_reg];
    assign count      = count_reg;

    always_comb begin
        rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        count_next  = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
        // Clear before set: when full, pop and push hit the same slot and it must stay valid.
        valid_next = valid_reg;
        if (pop)
            valid_next[rd_ptr_reg] = 1'b0;
        if (push)
            valid_next[wr_ptr_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= valid_next;
        end
    end

    // Payload storage is not reset; the valid bits qualify every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= in_addr;
            data_mem[wr_ptr_reg] <= in_data;
        end
    end

`ifdef RF_WBUF_FWD_EN
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] match1, match2;

    // Slot gi is the gi-th oldest entry; a higher gi is younger.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
        assign age_idx[gi] = rd_ptr_reg + PW'(gi);
        assign match1[gi]  = valid_reg[age_idx[gi]] && (addr_mem[age_idx[gi]] == rd_addr1);
        assign match2[gi]  = valid_reg[age_idx[gi]] && (addr_mem[age_idx[gi]] == rd_addr2);
    end

    assign fwd_hit1 = |match1;
    assign fwd_hit2 = |match2;

    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[i])
                fwd_data1 = data_mem[age_idx[i]];
            if (match2[i])
                fwd_data2 = data_mem[age_idx[i]];
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

`ifndef SYNTHESIS
    count_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
        count_reg == CW'($countones(valid_reg)));
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// Randomised self-checking bench for rf_write_buffer against a queue-based model of the buffer and register file.
// Forwarding expectations follow RF_WBUF_FWD_EN, matching the build of the design.
module tb_rf_write_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wr_stall, wr_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t          mq[$];
    logic [DW-1:0] exp_rf [16];
    logic [DW-1:0] rf_mem [16];
    int            wr_cnt = 0;
    bit            last_push;

    rf_write_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wr_stall(wr_stall), .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Register file: captures on negedge
    always @(negedge clk) begin
        if (wr_en) begin
            rf_mem[write_addr] <= write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic bit exp_pop();
        return (mq.size() != 0) && !wr_stall;
    endfunction

    function automatic bit exp_ready();
        return (mq.size() < DEPTH) || exp_pop();
    endfunction

    // Youngest pending entry with matching address; zero when forwarding is not built in.
    function automatic void model_fwd(input logic [AW-1:0] ra, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef RF_WBUF_FWD_EN
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == ra) begin
                hit = 1'b1;
                d   = mq[i].d;
                break;
            end
        end
`endif
    endfunction

    // Advance one clock and apply the buffer rules to the model.
    task automatic step();
        bit   p, pu;
        ent_t e;
        p  = exp_pop();
        pu = in_valid && exp_ready();
        e  = '{a: in_addr, d: in_data};
        @(posedge clk);
        last_push = 1'b0;
        if (rst_n) begin
            if (p) begin
                exp_rf[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (pu) begin
                mq.push_back(e);
                last_push = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_stall = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_chk++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit got %b%b want 00", fwd_hit1, fwd_hit2); end
        $display("reset: count=%0d in_ready=%b wr_en=%b", count, in_ready, wr_en);
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_addr = 4'd3; in_data = 32'hDEADBEEF;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        n_chk++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en got %b want 1", wr_en); end
        n_chk++; if (write_addr !== 4'd3 || write_data !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL single_write got %0d/%h want 3/deadbeef", write_addr, write_data); end
        step();
        n_chk++; if (count !== '0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL single_drained got count=%0d wr_en=%b want 0/0", count, wr_en); end
        n_chk++; if (rf_mem[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf got %h want deadbeef", rf_mem[3]); end
        $display("single push: r3=%h", rf_mem[3]);
    endtask

    task automatic test_fill_stall();
        wr_stall = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_valid = 1'b1; in_addr = AW'(i); in_data = DW'(i);
            #1;
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        #1;
        n_chk++; if (count !== CW'(DEPTH) || in_ready !== 1'b0 || wr_en !== 1'b0)
            begin n_fail++; $display("FAIL fill_full got count=%0d ready=%b wr_en=%b want 4/0/0", count, in_ready, wr_en); end
        wr_stall = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            #1;
            n_chk++; if (wr_en !== 1'b1 || write_addr !== AW'(k) || write_data !== DW'(k))
                begin n_fail++; $display("FAIL drain_order[%0d] got en=%b %0d/%h want 1 %0d/%h", k, wr_en, write_addr, write_data, k, k); end
            step();
        end
        n_chk++; if (count !== '0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL drain_empty got count=%0d wr_en=%b", count, wr_en); end
        $display("fill under stall then drain: 4 writes in order");
    endtask

    task automatic test_full_push();
        wr_stall = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_valid = 1'b1; in_addr = AW'(i); in_data = DW'(i);
            step();
        end
        wr_stall = 1'b0; in_addr = 4'd5; in_data = 32'd5;
        #1;
        n_chk++; if (in_ready !== 1'b1 || wr_en !== 1'b1)
            begin n_fail++; $display("FAIL fullpush_ready got ready=%b wr_en=%b want 1/1", in_ready, wr_en); end
        step();
        in_valid = 1'b0;
        n_chk++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fullpush_count got %0d want 4", count); end
        for (int k = 2; k <= 5; k++) begin
            #1;
            n_chk++; if (wr_en !== 1'b1 || write_addr !== mq[0].a || write_data !== mq[0].d || write_addr !== AW'(k))
                begin n_fail++; $display("FAIL fullpush_drain[%0d] got en=%b %0d/%h want 1 %0d", k, wr_en, write_addr, write_data, k); end
            step();
        end
        n_chk++; if (count !== '0) begin n_fail++; $display("FAIL fullpush_empty got %0d want 0", count); end
        $display("full+drain push: r5 written 4 cycles later");
    endtask

    task automatic test_forward();
        bit            eh;
        logic [DW-1:0] ed;
        wr_stall = 1'b1;
        in_valid = 1'b1; in_addr = 4'd7; in_data = 32'h11; step();
        in_data = 32'h22; step();
        in_valid = 1'b0; rd_addr1 = 4'd7; rd_addr2 = 4'd8;
        #1;
        model_fwd(rd_addr1, eh, ed);
        n_chk++; if (fwd_hit1 !== eh || fwd_data1 !== ed)
            begin n_fail++; $display("FAIL fwd_port1 got %b/%h want %b/%h", fwd_hit1, fwd_data1, eh, ed); end
        model_fwd(rd_addr2, eh, ed);
        n_chk++; if (fwd_hit2 !== eh) begin n_fail++; $display("FAIL fwd_port2 got %b want %b", fwd_hit2, eh); end
        $display("forward: hit1=%b data1=%h hit2=%b", fwd_hit1, fwd_data1, fwd_hit2);
        wr_stall = 1'b0;
        step(); step();
        n_chk++; if (rf_mem[7] !== 32'h22 || count !== '0) begin n_fail++; $display("FAIL fwd_drain got r7=%h count=%0d want 22/0", rf_mem[7], count); end
    endtask

    task automatic test_async_reset();
        int base;
        wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = AW'(10 + i); in_data = 32'hA000 + DW'(i);
            step();
        end
        in_valid = 1'b0; wr_stall = 1'b0;
        #1;
        n_chk++; if (wr_en !== 1'b1 || count !== CW'(3)) begin n_fail++; $display("FAIL arst_pre got en=%b count=%0d want 1/3", wr_en, count); end
        rst_n = 1'b0;
        mq.delete();
        #1;
        n_chk++; if (wr_en !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL arst_drop got en=%b count=%0d want 0/0", wr_en, count); end
        step();
        base = wr_cnt;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_chk++; if (wr_cnt !== base || count !== '0) begin n_fail++; $display("FAIL arst_nowrite got writes=%0d count=%0d want %0d/0", wr_cnt, count, base); end
        $display("async reset: pending entries discarded, writes=%0d", wr_cnt - base);
    endtask

    task automatic test_random();
        int            pushes = 0;
        int            cyc    = 0;
        bit            eh;
        logic [DW-1:0] ed;
        in_valid = 1'b0; wr_stall = 1'b0; last_push = 1'b0;
        while (pushes < 100 && cyc < 3000) begin
            if (in_valid && last_push) in_valid = 1'b0;
            else if (!in_valid) begin
                in_valid = 1'b1;
                in_addr  = AW'($urandom_range(0, 15));
                in_data  = $urandom;
            end
            wr_stall = ~wr_stall;
            rd_addr1 = AW'($urandom_range(0, 15));
            rd_addr2 = AW'($urandom_range(0, 15));
            #1;
            n_chk++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", cyc, count, mq.size()); end
            n_chk++; if (in_ready !== exp_ready() || wr_en !== exp_pop())
                begin n_fail++; $display("FAIL rnd_hs c%0d got ready=%b en=%b want %b/%b", cyc, in_ready, wr_en, exp_ready(), exp_pop()); end
            if (exp_pop()) begin
                n_chk++; if (write_addr !== mq[0].a || write_data !== mq[0].d)
                    begin n_fail++; $display("FAIL rnd_write c%0d got %0d/%h want %0d/%h", cyc, write_addr, write_data, mq[0].a, mq[0].d); end
            end
            model_fwd(rd_addr1, eh, ed);
            n_chk++; if (fwd_hit1 !== eh || (eh && fwd_data1 !== ed))
                begin n_fail++; $display("FAIL rnd_fwd1 c%0d got %b/%h want %b/%h", cyc, fwd_hit1, fwd_data1, eh, ed); end
            model_fwd(rd_addr2, eh, ed);
            n_chk++; if (fwd_hit2 !== eh || (eh && fwd_data2 !== ed))
                begin n_fail++; $display("FAIL rnd_fwd2 c%0d got %b/%h want %b/%h", cyc, fwd_hit2, fwd_data2, eh, ed); end
            step();
            if (last_push) pushes++;
            cyc++;
        end
        n_chk++; if (pushes < 100) begin n_fail++; $display("FAIL rnd_budget got %0d pushes want 100", pushes); end
        in_valid = 1'b0; wr_stall = 1'b0;
        while (mq.size() != 0 && cyc < 3100) begin step(); cyc++; end
        n_chk++; if (count !== '0) begin n_fail++; $display("FAIL rnd_drain got %0d want 0", count); end
        for (int r = 0; r < 16; r++) begin
            n_chk++; if (rf_mem[r] !== exp_rf[r]) begin n_fail++; $display("FAIL rnd_rf[%0d] got %h want %h", r, rf_mem[r], exp_rf[r]); end
        end
        $display("random: %0d pushes in %0d cycles, register file compared", pushes, cyc);
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_full_push();
        test_forward();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
